// File: rtl/psg_noise_write_decoder.sv
// PSG noise-channel register-write front end: decodes SN76489-style latch/data
// bytes into the noise control register and the tone-3 period, issues the
// LFSR restart strobe on noise writes, and throttles the bus with ready.
module psg_noise_write_decoder #(
  parameter int unsigned READY_CYCLES = 32,
  parameter int unsigned FREQ_BITS    = 10
) (
  input  logic                 clk,
  input  logic                 reset_lfsr,
  input  logic                 we,
  input  logic [7:0]           data,
  output logic                 ready,
  output logic [2:0]           noise_control,
  output logic [FREQ_BITS-1:0] tone3_freq,
  output logic                 restart_noise,
  output logic [2:0]           latched_addr
);

  localparam int unsigned CNT_W      = 8;
  localparam logic [CNT_W-1:0] READY_LOAD = CNT_W'(READY_CYCLES);
  localparam logic [2:0] ADDR_TONE2  = 3'b100;
  localparam logic [2:0] ADDR_NOISE  = 3'b110;

  logic [CNT_W-1:0] busy;
  logic             accept;

  // A byte is taken only while the bus is not being throttled.
  assign accept = we && ready;

  // Register decode, restart strobe and ready throttle counter.
  always_ff @(posedge clk or posedge reset_lfsr) begin
    if (reset_lfsr) begin
      noise_control <= 3'b000;
      tone3_freq    <= '0;
      latched_addr  <= 3'b000;
      restart_noise <= 1'b0;
      ready         <= 1'b1;
      busy          <= '0;
    end else begin
      restart_noise <= 1'b0;
      if (accept) begin
        busy  <= READY_LOAD;
        ready <= (READY_LOAD == '0);
        if (data[7]) begin
          latched_addr <= data[6:4];
          case (data[6:4])
            ADDR_TONE2: tone3_freq[3:0] <= data[3:0];
            ADDR_NOISE: begin
              noise_control <= data[2:0];
              restart_noise <= 1'b1;
            end
            default: ;
          endcase
        end else begin
          case (latched_addr)
            ADDR_TONE2: tone3_freq[9:4] <= data[5:0];
            ADDR_NOISE: begin
              noise_control <= data[2:0];
              restart_noise <= 1'b1;
            end
            default: ;
          endcase
        end
      end else if (busy != '0) begin
        busy  <= busy - CNT_W'(1);
        ready <= (busy == CNT_W'(1));
      end
    end
  end

endmodule

// File: doc/psg_noise_write_decoder.md
Name: psg_noise_write_decoder

Overview:
- Upstream register-write front end for the PSG noise channel, SN76489-style byte bus.
- Decodes latch and data bytes, and holds the 3-bit noise control register and the 10-bit tone-3 period.
- Outputs `noise_control` and `tone3_freq`, which feed the noise generator's `control`/`tone_freq` inputs.
- Emits the one-cycle `restart_noise` strobe on every noise-register write.
- Throttles the bus with a READY handshake.

Parameters:
- READY_CYCLES, 32: number of cycles `ready` stays low after an accepted write. Legal range 0..255; 0 means `ready` never drops.
- FREQ_BITS, 10: width of the tone-3 period. Fixed at 10; other values are unsupported.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset_lfsr  in  1  reset, asynchronous, active-high.
- we  in  1  write strobe; a byte is accepted on a rising clk edge when we=1 and ready=1.
- data  in  8  write byte.
- ready  out  1  1 = a write can be accepted this cycle.
- noise_control  out  3  {FB, NF1, NF0}; goes to the noise generator's `control` input.
- tone3_freq  out  FREQ_BITS  tone channel 2 period; goes to the noise generator's `tone_freq` input.
- restart_noise  out  1  one-cycle pulse, requests an LFSR restart.
- latched_addr  out  3  {channel[1:0], type} of the last latch byte; for debug/visibility.

Behaviour:
- Reset (async, reset_lfsr=1), all outputs and state clear immediately:
  - noise_control=3'b000, tone3_freq=0, latched_addr=3'b000.
  - restart_noise=0, ready=1, busy counter=0.
- Accepted write: we=1 AND ready=1 at a rising edge. Writes with ready=0 are dropped silently and change no state.
- Latch byte (data[7]=1):
  - latched_addr <= data[6:4].
  - If data[6:4]=3'b100 (tone ch2): tone3_freq[3:0] <= data[3:0]; tone3_freq[9:4] unchanged.
  - If data[6:4]=3'b110 (noise): noise_control <= data[2:0]; restart_noise pulses. data[3] is ignored.
  - Any other address: latch only, no register change.
- Data byte (data[7]=0), dispatched on the current latched_addr:
  - 3'b100: tone3_freq[9:4] <= data[5:0].
  - 3'b110: noise_control <= data[2:0]; restart_noise pulses.
  - Otherwise: no effect.
  - latched_addr is unchanged.
- restart_noise is registered: high for exactly the one cycle following the edge of the accepted noise write, then low.
  - Back-to-back accepted noise writes (READY_CYCLES=0) keep it high on consecutive cycles, one cycle per write.
- noise_control and tone3_freq update on the same edge as the accepting write, so they are valid in the same cycle restart_noise is high.
- Ready handshake:
  - An accepted write at edge N loads busy=READY_CYCLES.
  - ready = (busy==0). busy decrements each cycle while nonzero, so ready is low for exactly READY_CYCLES cycles, then high.
  - we held high continuously: one write accepted per READY_CYCLES+1 cycles.
  - The counter is 8-bit and saturates at 0; no wrap-around.
- Reset asserted mid-busy: ready returns to 1 immediately (asynchronously), and any pending restart pulse is cancelled.
- Reset deasserting in the same cycle as we=1: the write is accepted at the first edge where reset_lfsr=0.
- Data byte before any latch byte: latched_addr=000 applies, so the byte has no effect.
- No combinational path from we/data to any output.

Test Plan:
- Reset check: pulse reset_lfsr between edges → all outputs take reset values immediately, without a clock edge; ready=1.
- Noise write via latch: write 8'hE5 → next cycle noise_control=3'b101, restart_noise=1 for exactly 1 cycle, latched_addr=3'b110.
- Ready throttling: ready low for exactly 32 cycles after the write; a second write 8'hE2 during that window leaves noise_control=3'b101 with no restart pulse.
- Tone-3 two-byte write: write 8'hCA, wait for ready, then 8'h3F → tone3_freq=10'h3FA, and restart_noise never asserts.
- Data byte to noise latch: write 8'hE0, then data byte 8'h07 after ready → noise_control=3'b111, and a second restart pulse.
- Hold we=1 with READY_CYCLES=0: three latch writes to noise on consecutive edges → restart_noise high for 3 consecutive cycles.
- Reset mid-busy: assert reset_lfsr 10 cycles into a busy window → ready=1 immediately, and noise_control=0.
